l3_mem_responder: RTL and testbench
===================================

# l3_mem_responder

Memory-side responder for the cache hierarchy's downstream request interface. It accepts level-held read/write requests from an L2 cache, serves them from an internal word-addressed backing store after configurable latencies, and returns single-cycle ready pulses. It sits below one L2 instance as the shared L3 / main-memory model for simulation and FPGA bring-up.

## Interface
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, word width.
- MEM_DEPTH, 256, words of backing store (power of two, ≥ 2); IDX_W = $clog2(MEM_DEPTH).
- READ_LATENCY, 4, cycles from read accept to mem_read_ready (≥ 1).
- WRITE_LATENCY, 2, cycles from write accept to mem_write_ready (≥ 1).
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_read_req  in  1  read request, held by requester until mem_read_ready seen.
- mem_write_req  in  1  write request, held until mem_write_ready seen.
- mem_address  in  ADDR_WIDTH  word address; only bits [IDX_W-1:0] used, upper bits ignored (aliasing).
- mem_write_data  in  DATA_WIDTH  write data.
- mem_read_data  out  DATA_WIDTH  read data, valid with mem_read_ready, held until next read completes.
- mem_read_ready  out  1  one-cycle read completion pulse.
- mem_write_ready  out  1  one-cycle write completion pulse.
- busy  out  1  high in any state other than IDLE.
- rd_count  out  16  completed reads, saturating at 0xFFFF.
- wr_count  out  16  completed writes, saturating at 0xFFFF.

## Operation
- States: INIT, IDLE, WRITE, READ, WDONE, RDONE.
- INIT: after reset, sweeps index 0..MEM_DEPTH-1 writing 0, one word per cycle; requests ignored (remain pending on the bus); then IDLE.
- IDLE: on an edge with mem_write_req=1, captures index, write data, and pending_read = mem_read_req; goes to WRITE. Else if mem_read_req=1, captures index; goes to READ. Write has priority.
- WRITE: counts WRITE_LATENCY; on the final edge commits data to store[index], sets mem_write_ready, increments wr_count; goes to WDONE.
- WDONE: ready pulse cycle; next edge clears ready; goes to READ (same captured index, counter reloaded) if pending_read, else IDLE. Requests not sampled.
- READ: counts READ_LATENCY; on the final edge loads mem_read_data from store[index], sets mem_read_ready, increments rd_count; goes to RDONE.
- RDONE: ready pulse cycle; next edge clears ready; goes to IDLE. Requests not sampled.
- Captured address/data are fixed for the operation; a request dropped before its ready pulse still completes (commit and pulse occur).
- Read after write to the same index within a combined request returns the newly written data.

## Timing
- Reset values: mem_read_data=0, mem_read_ready=0, mem_write_ready=0, busy=1 (INIT), rd_count=0, wr_count=0; state=INIT, sweep pointer=0.
- Reset mid-operation: operation aborted, no commit, no ready pulse; INIT sweep restarts from 0.
- INIT lasts exactly MEM_DEPTH cycles after reset_n deasserts; busy low from the following cycle.
- Accept edge E0: ready high in the cycle following edge E0+LAT (LAT = READ_LATENCY or WRITE_LATENCY), for exactly one cycle.
- Combined write+read: write_ready after E0+WRITE_LATENCY, read_ready after E0+WRITE_LATENCY+1+READ_LATENCY.
- Back-to-back requests with req held continuously: one completion every LAT+2 cycles (ready cycle + one IDLE cycle).
- Ready pulses never overlap; at most one of mem_read_ready/mem_write_ready high per cycle.
- Counters stick at 0xFFFF; no wrap.

## Test plan
- Reset, release reset_n: busy high 256 cycles, then low; read 0x10 -> mem_read_ready 4 cycles after accept, mem_read_data=0, rd_count=1.
- Write 0xDEADBEEF to 0x25 -> mem_write_ready 2 cycles after accept, one cycle wide; read 0x25 -> 0xDEADBEEF; wr_count=1.
- Aliasing: write 0xCAFEF00D to 0x125, read 0x25 -> 0xCAFEF00D.
- Combined: mem_write_req=mem_read_req=1, address 0x40, data 0x12345678 -> write_ready at E0+2, read_ready at E0+7, mem_read_data=0x12345678.
- Drop mem_read_req one cycle after accept of read 0x25 -> ready still pulses at E0+4 with stored data.
- Assert reset_n low during WRITE of 0xAAAA5555 to 0x33 -> no ready pulse; after INIT, read 0x33 -> 0, counters 0.

Source files
------------

// File: rtl/l3_mem_responder.sv
// L3 / main-memory responder below one L2 instance.
// Word store with INIT sweep, write-then-read combine, latency counters.
`timescale 1ns/1ps
module l3_mem_responder #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_DEPTH     = 256,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_read_req,
  input  logic                  mem_write_req,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_read_ready,
  output logic                  mem_write_ready,
  output logic                  busy,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int MAXL  = (READ_LATENCY > WRITE_LATENCY) ?
                         READ_LATENCY : WRITE_LATENCY;
  localparam int LW    = $clog2(MAXL + 1);

  localparam logic [LW-1:0]    RL   = LW'(READ_LATENCY - 1);
  localparam logic [LW-1:0]    WL   = LW'(WRITE_LATENCY - 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(MEM_DEPTH - 1);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WDONE = 3'd4;
  localparam logic [2:0] S_RDONE = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  pend_q, pend_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rrdy_q, rrdy_d;
  logic                  wrdy_q, wrdy_d;
  logic [15:0]           rdcnt_q, rdcnt_d;
  logic [15:0]           wrcnt_q, wrcnt_d;

  logic                  we;
  logic [IDX_W-1:0]      waddr;
  logic [DATA_WIDTH-1:0] wval;
  logic [DATA_WIDTH-1:0] store_q [MEM_DEPTH];

  // Upper address bits alias onto the same word.
  logic unused_addr;
  assign unused_addr = ^mem_address[ADDR_WIDTH-1:IDX_W];

  // Next-state, store write port and completion bookkeeping.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rrdy_d  = 1'b0;
    wrdy_d  = 1'b0;
    rdcnt_d = rdcnt_q;
    wrcnt_d = wrcnt_q;
    we      = 1'b0;
    waddr   = idx_q;
    wval    = wdata_q;
    unique case (state_q)
      S_INIT: begin
        we    = 1'b1;
        waddr = ptr_q;
        wval  = '0;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (mem_write_req) begin
          idx_d   = mem_address[IDX_W-1:0];
          wdata_d = mem_write_data;
          pend_d  = mem_read_req;
          cnt_d   = WL;
          state_d = S_WRITE;
        end else if (mem_read_req) begin
          idx_d   = mem_address[IDX_W-1:0];
          pend_d  = 1'b0;
          cnt_d   = RL;
          state_d = S_READ;
        end
      end
      S_WRITE: begin
        if (cnt_q == '0) begin
          we      = 1'b1;
          wrdy_d  = 1'b1;
          if (wrcnt_q != 16'hFFFF) wrcnt_d = wrcnt_q + 16'd1;
          state_d = S_WDONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WDONE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          cnt_d   = RL;
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (cnt_q == '0) begin
          rdata_d = store_q[idx_q];
          rrdy_d  = 1'b1;
          if (rdcnt_q != 16'hFFFF) rdcnt_d = rdcnt_q + 16'd1;
          state_d = S_RDONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RDONE: state_d = S_IDLE;
      default: begin
        state_d = S_INIT;
        ptr_d   = '0;
      end
    endcase
    if (!reset_n) we = 1'b0;
  end

  // Control and output registers; reset aborts any operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rrdy_q  <= 1'b0;
      wrdy_q  <= 1'b0;
      rdcnt_q <= '0;
      wrcnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rrdy_q  <= rrdy_d;
      wrdy_q  <= wrdy_d;
      rdcnt_q <= rdcnt_d;
      wrcnt_q <= wrcnt_d;
    end
  end

  // Backing store; cleared by the INIT sweep instead of reset.
  always_ff @(posedge clk) begin
    if (we) store_q[waddr] <= wval;
  end

  assign mem_read_data   = rdata_q;
  assign mem_read_ready  = rrdy_q;
  assign mem_write_ready = wrdy_q;
  assign busy            = (state_q != S_IDLE);
  assign rd_count        = rdcnt_q;
  assign wr_count        = wrcnt_q;

endmodule

// File: tb/tb_l3_mem_responder.sv
// Scoreboard bench for l3_mem_responder.
// Driver pushes expected completions; negedge monitor pops and checks.
`timescale 1ns/1ps
module tb_l3_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_read_req;
  logic        mem_write_req;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_read_ready;
  logic        mem_write_ready;
  logic        busy;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  l3_mem_responder dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mem_read_req    (mem_read_req),
    .mem_write_req   (mem_write_req),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .mem_read_data   (mem_read_data),
    .mem_read_ready  (mem_read_ready),
    .mem_write_ready (mem_write_ready),
    .busy            (busy),
    .rd_count        (rd_count),
    .wr_count        (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timeout (cyc %0d)", nm, cyc);
  endtask

  // Monitor: every ready pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && (mem_read_ready || mem_write_ready)) begin
      chk("overlap", {31'd0, mem_read_ready & mem_write_ready}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_ready", {31'd0, mem_read_ready}, 32'd2);
      end else begin
        e = sb.pop_front();
        chk("kind", {31'd0, mem_read_ready}, {31'd0, e.is_rd});
        chk("ready_cycle", cyc, e.cyc);
        if (e.is_rd) chk("rdata", mem_read_data, e.data);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 600; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    tmo("wait_idle");
  endtask

  task automatic wait_rdy(input bit rd);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rd ? mem_read_ready : mem_write_ready) return;
    end
    tmo(rd ? "read_ready" : "write_ready");
  endtask

  // Called right after reset_n rises at a negedge; edges 1..255
  // still sweep, edge 256 lands in IDLE.
  task automatic check_init_len();
    int n = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("init_len", n, 255);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d);
    wait_idle();
    mem_address  = a;
    mem_read_req = 1'b1;
    sb.push_back('{1'b1, d, cyc + 1 + 4});
    wait_rdy(1'b1);
    mem_read_req = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    wait_idle();
    mem_address    = a;
    mem_write_data = d;
    mem_write_req  = 1'b1;
    sb.push_back('{1'b0, d, cyc + 1 + 2});
    wait_rdy(1'b0);
    mem_write_req = 1'b0;
  endtask

  initial begin
    #300us;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    reset_n        = 1'b0;
    mem_read_req   = 1'b0;
    mem_write_req  = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_rrdy", {31'd0, mem_read_ready}, 32'd0);
    chk("rst_wrdy", {31'd0, mem_write_ready}, 32'd0);
    chk("rst_rdata", mem_read_data, 32'd0);
    chk("rst_rdcnt", {16'd0, rd_count}, 32'd0);
    chk("rst_wrcnt", {16'd0, wr_count}, 32'd0);
    reset_n = 1'b1;
    check_init_len();

    do_read(32'h10, 32'h0);
    chk("rdcnt1", {16'd0, rd_count}, 32'd1);

    do_write(32'h25, 32'hDEADBEEF);
    chk("wrcnt1", {16'd0, wr_count}, 32'd1);
    do_read(32'h25, 32'hDEADBEEF);

    do_write(32'h125, 32'hCAFEF00D);
    do_read(32'h25, 32'hCAFEF00D);
    chk("wrcnt2", {16'd0, wr_count}, 32'd2);
    chk("rdcnt3", {16'd0, rd_count}, 32'd3);

    // Combined write+read: write at E0+2, read at E0+2+1+4.
    wait_idle();
    mem_address    = 32'h40;
    mem_write_data = 32'h12345678;
    mem_write_req  = 1'b1;
    mem_read_req   = 1'b1;
    e0 = cyc + 1;
    sb.push_back('{1'b0, 32'h12345678, e0 + 2});
    sb.push_back('{1'b1, 32'h12345678, e0 + 7});
    wait_rdy(1'b0);
    mem_write_req = 1'b0;
    wait_rdy(1'b1);
    mem_read_req = 1'b0;
    chk("wrcnt3", {16'd0, wr_count}, 32'd3);
    chk("rdcnt4", {16'd0, rd_count}, 32'd4);

    // Request dropped right after accept still completes.
    wait_idle();
    mem_address  = 32'h25;
    mem_read_req = 1'b1;
    sb.push_back('{1'b1, 32'hCAFEF00D, cyc + 1 + 4});
    @(negedge clk);
    mem_read_req = 1'b0;
    mem_address  = 32'h10;
    wait_rdy(1'b1);
    chk("rdcnt5", {16'd0, rd_count}, 32'd5);

    // Reset during WRITE: no commit, no pulse, counters cleared.
    wait_idle();
    mem_address    = 32'h33;
    mem_write_data = 32'hAAAA5555;
    mem_write_req  = 1'b1;
    @(negedge clk);
    reset_n       = 1'b0;
    mem_write_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b1;
    check_init_len();
    chk("abort_rdcnt", {16'd0, rd_count}, 32'd0);
    chk("abort_wrcnt", {16'd0, wr_count}, 32'd0);
    do_read(32'h33, 32'h0);
    chk("post_rdcnt", {16'd0, rd_count}, 32'd1);

    repeat (10) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
